// File: rtl/wb_sram_memtest_if.sv
// Wishbone classic bus between the memory-test initiator and its responder.
interface wb_sram_memtest_if #(
  parameter int ADR_W = 17
);
  logic             cyc_o;
  logic             stb_o;
  logic             we_o;
  logic [3:0]       sel_o;
  logic [ADR_W-1:0] adr_o;
  logic [31:0]      dat_o;
  logic [31:0]      dat_i;
  logic             ack_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/wb_sram_memtest.sv
// Wishbone initiator that writes seed^address to a word range, reads it back and
// reports the first mismatch or missing ack.
module wb_sram_memtest #(
  parameter int ADR_W   = 17,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADR_W-1:0]  base,
  input  logic [ADR_W-3:0]  length,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ADR_W-1:0]  err_adr,
  output logic [31:0]       err_dat,
  wb_sram_memtest_if.master wb
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [ADR_W-1:0] cur_q, cur_d, base_q, base_d;
  logic [ADR_W-3:0] rem_q, rem_d, len_q, len_d;
  logic [31:0]      seed_q, seed_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d, to_q, to_d;
  logic [ADR_W-1:0] err_adr_q, err_adr_d;
  logic [31:0]      err_dat_q, err_dat_d;
  logic             req, last, wait_exp;
  logic [31:0]      exp_dat;

  function automatic logic [31:0] pat(input logic [31:0] s, input logic [ADR_W-1:0] a);
    pat = s ^ 32'(a);
  endfunction

  assign req      = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign last     = (rem_q == (ADR_W-2)'(1));
  assign wait_exp = (wcnt_q == 8'(TIMEOUT - 1));
  assign exp_dat  = pat(seed_q, cur_q);

  // Bus outputs are pure decodes of state so they stay stable while stb_o is high.
  assign wb.cyc_o = req;
  assign wb.stb_o = req;
  assign wb.we_o  = (state_q == WR_REQ);
  assign wb.sel_o = req ? 4'hF : 4'h0;
  assign wb.adr_o = req ? cur_q : '0;
  assign wb.dat_o = (state_q == WR_REQ) ? exp_dat : '0;

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = to_q;
  assign err_adr = err_adr_q;
  assign err_dat = err_dat_q;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    base_d    = base_q;
    rem_d     = rem_q;
    len_d     = len_q;
    seed_d    = seed_q;
    wcnt_d    = wcnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    to_d      = to_q;
    err_adr_d = err_adr_q;
    err_dat_d = err_dat_q;
    case (state_q)
      IDLE: if (start) begin
        done_d    = 1'b0;
        pass_d    = 1'b0;
        to_d      = 1'b0;
        err_adr_d = '0;
        err_dat_d = '0;
        base_d    = base & ~(ADR_W'(3));
        cur_d     = base & ~(ADR_W'(3));
        len_d     = length;
        rem_d     = length;
        seed_d    = seed;
        wcnt_d    = '0;
        if (length != '0) begin
          busy_d  = 1'b1;
          state_d = WR_REQ;
        end else begin
          done_d  = 1'b1;
          pass_d  = 1'b1;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        if (wb.ack_i) begin
          state_d = WR_GAP;
        end else if (wait_exp) begin
          to_d      = 1'b1;
          err_adr_d = cur_q;
          err_dat_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      WR_GAP: begin
        wcnt_d = '0;
        if (last) begin
          cur_d   = base_q;
          rem_d   = len_q;
          state_d = RD_REQ;
        end else begin
          cur_d   = cur_q + ADR_W'(4);
          rem_d   = rem_q - (ADR_W-2)'(1);
          state_d = WR_REQ;
        end
      end
      RD_REQ: begin
        // An ack on the timeout edge still counts as a normal completion.
        if (wb.ack_i) begin
          if (wb.dat_i != exp_dat) begin
            err_adr_d = cur_q;
            err_dat_d = wb.dat_i;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = RD_GAP;
          end
        end else if (wait_exp) begin
          to_d      = 1'b1;
          err_adr_d = cur_q;
          err_dat_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      RD_GAP: begin
        wcnt_d = '0;
        if (last) begin
          pass_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cur_d   = cur_q + ADR_W'(4);
          rem_d   = rem_q - (ADR_W-2)'(1);
          state_d = RD_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      to_q      <= 1'b0;
      err_adr_q <= '0;
      err_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      to_q      <= to_d;
      err_adr_q <= err_adr_d;
      err_dat_q <= err_dat_d;
    end
  end

  // Walk registers are only consumed in REQ/GAP states, which reset never leaves us in.
  always_ff @(posedge clk) begin
    cur_q  <= cur_d;
    base_q <= base_d;
    rem_q  <= rem_d;
    len_q  <= len_d;
    seed_q <= seed_d;
    wcnt_q <= wcnt_d;
  end
endmodule

// File: tb/tb_wb_sram_memtest.sv
// Randomized bench for wb_sram_memtest: memory responder with variable latency,
// injectable stuck bits and missing acks, checked against a transaction-level model.
module tb_wb_sram_memtest;
  localparam int ADR_W   = 17;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic        we;
    logic [16:0] adr;
    logic [31:0] dat;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [ADR_W-1:0]  base;
  logic [ADR_W-3:0]  length;
  logic [31:0]       seed;
  logic              busy, done, pass, timeout;
  logic [ADR_W-1:0]  err_adr;
  logic [31:0]       err_dat;

  wb_sram_memtest_if #(.ADR_W(ADR_W)) wb ();

  wb_sram_memtest #(.ADR_W(ADR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .length(length), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_adr(err_adr), .err_dat(err_dat), .wb(wb.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Responder state and fault injection knobs.
  logic [31:0] mem [int];
  txn_t        obs [$];
  txn_t        exp_q [$];
  int          hold = 0, lat = 1, max_lat = 1, acc_idx = 0, noack_idx = -1, to_hold = 0;
  bit          fault_en = 0, stray_en = 0;
  logic [16:0] fault_adr = '0;
  logic [31:0] fault_mask = '0;
  logic [49:0] held;
  logic [31:0] rd;
  txn_t        t;

  always @(negedge clk) begin
    if (rst || !wb.stb_o) begin
      wb.ack_i = stray_en ? 1'($urandom_range(1, 0)) : 1'b0;
      wb.dat_i = $urandom;
      hold = 0;
    end else begin
      if (hold == 0) begin
        lat = $urandom_range(max_lat, 1);
        acc_idx++;
        held = {wb.we_o, wb.adr_o, wb.dat_o};
        chk("sel", 64'(wb.sel_o), 64'hF);
      end else begin
        chk("stable", 64'({wb.we_o, wb.adr_o, wb.dat_o}), 64'(held));
      end
      hold++;
      if (acc_idx == noack_idx) to_hold = hold;
      if (hold >= lat && acc_idx != noack_idx) begin
        wb.ack_i = 1'b1;
        if (wb.we_o) begin
          mem[int'(wb.adr_o)] = wb.dat_o;
          t = '{we: 1'b1, adr: wb.adr_o, dat: wb.dat_o};
        end else begin
          rd = mem.exists(int'(wb.adr_o)) ? mem[int'(wb.adr_o)] : 32'h0;
          if (fault_en && wb.adr_o == fault_adr) rd = rd | fault_mask;
          wb.dat_i = rd;
          t = '{we: 1'b0, adr: wb.adr_o, dat: rd};
        end
        obs.push_back(t);
      end else begin
        wb.ack_i = 1'b0;
        wb.dat_i = $urandom;
      end
    end
  end

  // Expected transaction list and verdict from the test rules alone.
  logic        exp_pass, exp_to;
  logic [16:0] exp_eadr;
  logic [31:0] exp_edat;

  task automatic model(input logic [16:0] b, input int len, input logic [31:0] s);
    logic [16:0] a0, a;
    logic [31:0] v;
    int acc;
    exp_q.delete();
    exp_pass = 1'b1; exp_to = 1'b0; exp_eadr = '0; exp_edat = '0;
    a0 = b & ~17'h3;
    acc = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < len; i++) begin
        a = a0 + 17'(4 * i);
        acc++;
        if (acc == noack_idx) begin
          exp_pass = 1'b0; exp_to = 1'b1; exp_eadr = a;
          return;
        end
        v = s ^ {15'h0, a};
        if (ph == 1 && fault_en && a == fault_adr) v = v | fault_mask;
        exp_q.push_back('{we: (ph == 0), adr: a, dat: v});
        if (ph == 1 && v != (s ^ {15'h0, a})) begin
          exp_pass = 1'b0; exp_eadr = a; exp_edat = v;
          return;
        end
      end
    end
  endtask

  function automatic logic [63:0] obs_at(input int i);
    return (obs.size() > i) ? 64'(obs[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic chk_idle_outs(input string tag);
    chk({tag, ":ctl"}, 64'({busy, done, pass, timeout, wb.cyc_o, wb.stb_o, wb.we_o, wb.sel_o}), 64'h0);
    chk({tag, ":err"}, 64'({err_adr, err_dat}), 64'h0);
    chk({tag, ":bus"}, 64'({wb.adr_o, wb.dat_o}), 64'h0);
  endtask

  task automatic run_test(input string tag, input logic [16:0] b, input int len,
                          input logic [31:0] s, input bit mid_start, output int n);
    model(b, len, s);
    obs.delete();
    acc_idx = 0;
    to_hold = 0;
    @(negedge clk);
    base = b; length = 15'(len); seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
      if (mid_start && n == 5) begin start = 1'b1; base = b + 17'h40; end
      if (mid_start && n == 6) start = 1'b0;
    end
    chk({tag, ":done"}, 64'(done), 64'h1);
    chk({tag, ":busy"}, 64'(busy), 64'h0);
    chk({tag, ":pass"}, 64'(pass), 64'(exp_pass));
    chk({tag, ":timeout"}, 64'(timeout), 64'(exp_to));
    chk({tag, ":err_adr"}, 64'(err_adr), 64'(exp_eadr));
    chk({tag, ":err_dat"}, 64'(err_dat), 64'(exp_edat));
    chk({tag, ":ntxn"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) chk({tag, ":txn"}, obs_at(i), 64'(exp_q[i]));
    repeat (3) @(negedge clk);
    chk({tag, ":held"}, 64'({done, pass, busy, wb.stb_o}), 64'({1'b1, exp_pass, 1'b0, 1'b0}));
  endtask

  int n;
  int len;
  logic [16:0] b;

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; length = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk_idle_outs("reset");
    rst = 1'b0;

    run_test("clean", 17'h00100, 4, 32'hDEAD0000, 1'b0, n);
    chk("clean:cycles", 64'(n), 64'd16);
    chk("clean:wr0", obs_at(0), 64'({1'b1, 17'h00100, 32'hDEAD0100}));
    chk("clean:wr3", obs_at(3), 64'({1'b1, 17'h0010C, 32'hDEAD010C}));

    max_lat = 3; fault_en = 1; fault_adr = 17'h00108; fault_mask = 32'h10;
    run_test("stuck", 17'h00100, 4, 32'hDEAD0000, 1'b0, n);
    chk("stuck:err_dat_const", 64'(err_dat), 64'hDEAD0118);

    fault_en = 0; noack_idx = 3;
    run_test("noack", 17'h00200, 6, $urandom, 1'b0, n);
    chk("noack:stb_cycles", 64'(to_hold), 64'(TIMEOUT));
    chk("noack:err_adr_const", 64'(err_adr), 64'h00208);

    noack_idx = -1; max_lat = 2;
    run_test("wrap", 17'h1FFF8, 4, $urandom, 1'b0, n);
    chk("wrap:adr2", 64'(obs_at(2) >> 32) & 64'h1FFFF, 64'h0);

    run_test("len0", 17'h00040, 0, $urandom, 1'b0, n);
    chk("len0:accesses", 64'(acc_idx), 64'h0);

    run_test("midstart", 17'h00300, 5, $urandom, 1'b1, n);

    // Reset while a read is outstanding, with start asserted on the same edge.
    max_lat = 3;
    obs.delete(); acc_idx = 0;
    @(negedge clk);
    base = 17'h00400; length = 15'd4; seed = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(wb.stb_o && !wb.we_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rstrd:reached", 64'(wb.stb_o && !wb.we_o), 64'h1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk_idle_outs("rstrd");
    repeat (5) @(negedge clk);
    chk("rstrd:quiet", 64'({done, busy, wb.stb_o}), 64'h0);
    run_test("after_rst", 17'h00400, 4, $urandom, 1'b0, n);

    stray_en = 1;
    for (int it = 0; it < 12; it++) begin
      b = 17'($urandom);
      len = $urandom_range(8, 1);
      max_lat = $urandom_range(4, 1);
      fault_en = 1'($urandom_range(1, 0));
      fault_adr = (b & ~17'h3) + 17'(4 * $urandom_range(len - 1, 0));
      fault_mask = 32'h1 << $urandom_range(31, 0);
      noack_idx = ($urandom_range(3, 0) == 0) ? $urandom_range(2 * len, 1) : -1;
      run_test("rand", b, len, $urandom, 1'b0, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
